// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the handshaked sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;

  localparam int FLG_Z   = 0;
  localparam int FLG_C   = 1;
  localparam int FLG_V   = 2;
  localparam int FLG_N   = 3;
  localparam int FLG_ERR = 4;
  localparam int NFLG    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between the operand source and the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [4:0]       out_flags;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res, out_flags
  );
endinterface

// File: rtl/alu_seq_shift_unit.sv
// Iterative one-bit-per-cycle shifter: work register plus down-counter.
// o_res/o_bit are the value and the bit leaving the register on the current cycle.
module alu_seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_dir,
  input  logic [SHW-1:0]   i_amt,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic             r_dir;

  // i_dir=1 is a logical right shift, 0 a left shift
  assign o_res  = r_dir ? {1'b0, r_work[WIDTH-1:1]} : {r_work[WIDTH-2:0], 1'b0};
  assign o_bit  = r_dir ? r_work[0] : r_work[WIDTH-1];
  assign o_busy = (r_cnt != '0);
  assign o_done = (r_cnt == SHW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
    end else if (i_load) begin
      r_work <= i_data;
      r_cnt  <= i_amt;
      r_dir  <= i_dir;
    end else if (o_busy) begin
      r_work <= o_res;
      r_cnt  <= r_cnt - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: one op per transaction, result and {ERR,N,V,C,Z} held until accepted.
// Non-shift ops and zero-amount shifts take 1 cycle; shifts by amt>0 take amt+1 cycles.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_res;
  logic [NFLG-1:0]  r_flags;
  logic [WIDTH-1:0] w_res_nxt;
  logic [NFLG-1:0]  w_flags_nxt;
  logic             w_in_ready;
  logic             w_capture;
  logic             w_shift_go;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_op_res;
  logic [NFLG-1:0]  w_op_flags;
  logic             w_c;
  logic             w_v;
  logic             w_err;

  logic             w_sh_busy;
  logic             w_sh_done;
  logic             w_sh_bit;
  logic [WIDTH-1:0] w_sh_res;
  logic [NFLG-1:0]  w_sh_flags;
  logic [SHW-1:0]   w_amt;

  assign w_amt = bus.in_b[SHW-1:0];

  alu_seq_shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_shift_go),
    .i_dir  (bus.in_op == OP_SHR),
    .i_amt  (w_amt),
    .i_data (bus.in_a),
    .o_busy (w_sh_busy),
    .o_done (w_sh_done),
    .o_res  (w_sh_res),
    .o_bit  (w_sh_bit)
  );

  always_comb begin
    w_sum    = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    w_diff   = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    w_op_res = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_err    = 1'b0;
    case (bus.in_op)
      OP_ADD: begin
        w_op_res = w_sum[MSB:0];
        w_c      = w_sum[WIDTH];
        w_v      = (bus.in_a[MSB] == bus.in_b[MSB]) && (w_sum[MSB] != bus.in_a[MSB]);
      end
      OP_SUB: begin
        w_op_res = w_diff[MSB:0];
        w_c      = w_diff[WIDTH];
        w_v      = (bus.in_a[MSB] != bus.in_b[MSB]) && (w_diff[MSB] != bus.in_a[MSB]);
      end
      OP_AND:  w_op_res = bus.in_a & bus.in_b;
      OP_OR:   w_op_res = bus.in_a | bus.in_b;
      OP_XOR:  w_op_res = bus.in_a ^ bus.in_b;
      OP_NAND: w_op_res = ~(bus.in_a & bus.in_b);
      // only zero-amount shifts complete here; the rest go through the shift unit
      OP_SHL, OP_SHR: w_op_res = bus.in_a;
      OP_CMP: begin
        w_op_res[0] = bus.in_a <  bus.in_b;
        w_op_res[1] = bus.in_a == bus.in_b;
        w_op_res[2] = bus.in_a >  bus.in_b;
      end
      default: w_err = 1'b1;
    endcase

    w_op_flags          = '0;
    w_op_flags[FLG_ERR] = w_err;
    if (!w_err) begin
      w_op_flags[FLG_Z] = (w_op_res == '0);
      w_op_flags[FLG_N] = w_op_res[MSB];
      w_op_flags[FLG_C] = w_c;
      w_op_flags[FLG_V] = w_v;
    end

    w_sh_flags        = '0;
    w_sh_flags[FLG_Z] = (w_sh_res == '0);
    w_sh_flags[FLG_N] = w_sh_res[MSB];
    w_sh_flags[FLG_C] = w_sh_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_capture   = 1'b0;
    w_shift_go  = 1'b0;
    w_res_nxt   = w_op_res;
    w_flags_nxt = w_op_flags;
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
      ST_SHIFT: begin
        if (w_sh_done) begin
          w_capture   = 1'b1;
          w_res_nxt   = w_sh_res;
          w_flags_nxt = w_sh_flags;
          w_state_nxt = ST_DONE;
        end else if (!w_sh_busy) begin
          // shifter idle without finishing: recover rather than hang
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_in_ready = bus.out_ready;
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // an accept in DONE overrides the return to IDLE, giving back-to-back ops
    if (w_in_ready && bus.in_valid) begin
      if (is_shift(bus.in_op) && (w_amt != '0)) begin
        w_shift_go  = 1'b1;
        w_state_nxt = ST_SHIFT;
      end else begin
        w_capture   = 1'b1;
        w_state_nxt = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res   <= '0;
      r_flags <= '0;
    end else if (w_capture) begin
      r_res   <= w_res_nxt;
      r_flags <= w_flags_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_res   = r_res;
  assign bus.out_flags = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed 8-bit vectors and corner sequences, then random 16-bit ops vs a model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  b8();
  alu_seq_if #(.WIDTH(16)) b16();

  alu_seq #(.WIDTH(8),  .SHW(3)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  alu_seq #(.WIDTH(16), .SHW(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  logic        sel16 = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = 4'd0;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic        or_force = 1'b1;
  logic        rnd_stall = 1'b0;
  logic        r_rnd = 1'b1;
  logic        out_ready;

  assign out_ready     = rnd_stall ? r_rnd : or_force;
  assign b8.in_valid   = in_valid && !sel16;
  assign b8.in_op      = in_op;
  assign b8.in_a       = in_a[7:0];
  assign b8.in_b       = in_b[7:0];
  assign b8.out_ready  = out_ready;
  assign b16.in_valid  = in_valid && sel16;
  assign b16.in_op     = in_op;
  assign b16.in_a      = in_a;
  assign b16.in_b      = in_b;
  assign b16.out_ready = out_ready;

  logic        w_ov, w_ir;
  logic [15:0] w_res;
  logic [4:0]  w_fl;
  assign w_ov  = sel16 ? b16.out_valid : b8.out_valid;
  assign w_ir  = sel16 ? b16.in_ready  : b8.in_ready;
  assign w_res = sel16 ? b16.out_res   : {8'h00, b8.out_res};
  assign w_fl  = sel16 ? b16.out_flags : b8.out_flags;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  fl;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  exp_t q[$];
  vec_t vt[20];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_acc = -1;
  int   last_fire = -2;
  bit   head_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    r_rnd = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: event did not occur / unexpected event", nm);
  endtask

  // reference model, signed overflow derived from integer arithmetic
  function automatic void model(input int w, input logic [3:0] op, input logic [15:0] a,
                                input logic [15:0] b, output logic [15:0] res,
                                output logic [4:0] fl, output int lat);
    int m, half, ua, ub, sa, sb, s, r, amt;
    bit c, v, err;
    m = (1 << w) - 1;  half = 1 << (w - 1);
    ua = int'(a) & m;  ub = int'(b) & m;  amt = ub & (w - 1);
    sa = (ua >= half) ? ua - (1 << w) : ua;
    sb = (ub >= half) ? ub - (1 << w) : ub;
    c = 0; v = 0; err = 0; lat = 1; r = 0;
    case (op)
      4'd0: begin r = ua + ub; c = (r > m);   s = sa + sb; v = (s >= half) || (s < -half); end
      4'd1: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s >= half) || (s < -half); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = ~(ua & ub);
      4'd6: begin
        r = ua << amt;
        if (amt != 0) begin c = ((ua >> (w - amt)) & 1) != 0; lat = amt + 1; end
      end
      4'd7: begin
        r = ua >> amt;
        if (amt != 0) begin c = ((ua >> (amt - 1)) & 1) != 0; lat = amt + 1; end
      end
      4'd8: r = (ua < ub ? 1 : 0) | (ua == ub ? 2 : 0) | (ua > ub ? 4 : 0);
      default: err = 1;
    endcase
    r   = r & m;
    res = 16'(r);
    fl  = err ? 5'b10000 : {1'b0, (r >= half), v, c, (r == 0)};
  endfunction

  // called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] res, input logic [4:0] fl, input int lat,
                      input string nm);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (w_ir) begin
        acc = 1'b1;
        last_acc = cyc;
        q.push_back('{res: res, fl: fl, lat: lat, acc: cyc, nm: nm});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) fail_now({nm, " accept"});
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && q.size() != 0; t++) @(negedge clk);
    if (q.size() != 0) begin
      fail_now("drain");
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (w_ov && !head_seen) begin
        head_seen = 1'b1;
        if (q.size() == 0) fail_now("spurious out_valid");
        else chk({q[0].nm, " latency"}, 32'(cyc - q[0].acc), 32'(q[0].lat));
      end
      if (w_ov && out_ready) begin
        last_fire = cyc;
        head_seen = 1'b0;
        if (q.size() != 0) begin
          chk({q[0].nm, " res"},   32'(w_res), 32'(q[0].res));
          chk({q[0].nm, " flags"}, 32'(w_fl),  32'(q[0].fl));
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    logic [15:0] e_res;
    logic [4:0]  e_fl;
    int          e_lat;
    logic [3:0]  r_op;
    logic [15:0] r_a, r_b;

    //          op       a       b       res     {E,N,V,C,Z} lat
    vt[0]  = '{OP_ADD,  16'hFF, 16'h01, 16'h00, 5'b00011, 1};
    vt[1]  = '{OP_SUB,  16'h80, 16'h01, 16'h7F, 5'b00100, 1};
    vt[2]  = '{OP_CMP,  16'h03, 16'h07, 16'h01, 5'b00000, 1};
    vt[3]  = '{4'd12,   16'h55, 16'hAA, 16'h00, 5'b10000, 1};
    vt[4]  = '{OP_SHL,  16'h81, 16'h03, 16'h08, 5'b00000, 4};
    vt[5]  = '{OP_SHR,  16'h01, 16'h01, 16'h00, 5'b00011, 2};
    vt[6]  = '{OP_SHL,  16'hA5, 16'h00, 16'hA5, 5'b01000, 1};
    vt[7]  = '{OP_ADD,  16'h7F, 16'h01, 16'h80, 5'b01100, 1};
    vt[8]  = '{OP_SUB,  16'h03, 16'h05, 16'hFE, 5'b01010, 1};
    vt[9]  = '{OP_NAND, 16'hF0, 16'hFF, 16'h0F, 5'b00000, 1};
    vt[10] = '{OP_OR,   16'h00, 16'h00, 16'h00, 5'b00001, 1};
    vt[11] = '{OP_CMP,  16'h09, 16'h09, 16'h02, 5'b00000, 1};
    vt[12] = '{OP_CMP,  16'h0A, 16'h02, 16'h04, 5'b00000, 1};
    vt[13] = '{OP_SHR,  16'h80, 16'h07, 16'h01, 5'b00000, 8};
    vt[14] = '{OP_SHL,  16'h01, 16'h0F, 16'h80, 5'b01000, 8};
    vt[15] = '{OP_SHL,  16'hC0, 16'h02, 16'h00, 5'b00011, 3};
    vt[16] = '{OP_AND,  16'h3C, 16'h0F, 16'h0C, 5'b00000, 1};
    vt[17] = '{OP_XOR,  16'hFF, 16'hFF, 16'h00, 5'b00001, 1};
    vt[18] = '{4'd15,   16'h12, 16'h34, 16'h00, 5'b10000, 1};
    vt[19] = '{OP_SHR,  16'h80, 16'h08, 16'h80, 5'b01000, 1};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset out_valid", 32'(b8.out_valid), 32'd0);
    chk("reset out_res",   32'(b8.out_res),   32'd0);
    chk("reset out_flags", 32'(b8.out_flags), 32'd0);
    chk("reset in_ready",  32'(b8.in_ready),  32'd1);
    chk("reset w16 out_valid", 32'(b16.out_valid), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++)
      send(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].fl, vt[i].lat, $sformatf("vec%0d", i));
    drain();

    send(OP_SHL, 16'h81, 16'h03, 16'h08, 5'b00000, 4, "shl3");
    n = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (w_ir) break;
      n++;
    end
    chk("shl3 in_ready low cycles", 32'(n), 32'd3);
    drain();

    // backpressure: result must hold, then release and accept in the same cycle
    or_force = 1'b0;
    send(OP_XOR, 16'h5A, 16'hFF, 16'hA5, 5'b01000, 1, "bp xor");
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (w_res !== 16'hA5 || w_fl !== 5'b01000 || w_ir !== 1'b0 || w_ov !== 1'b1) n++;
    end
    chk("bp hold stable", 32'(n), 32'd0);
    @(posedge clk); #1;
    or_force = 1'b1;
    send(OP_AND, 16'h3C, 16'hF0, 16'h30, 5'b00000, 1, "bp and");
    chk("bp same-cycle transfer", 32'(last_fire), 32'(last_acc));
    drain();
    chk("persist out_valid", 32'(w_ov), 32'd0);
    chk("persist out_res", 32'(w_res), 32'h30);

    // reset in the third shift cycle of a 6-bit shift
    send(OP_SHL, 16'h03, 16'h06, 16'hC0, 5'b01000, 7, "rst shl");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(b8.out_valid), 32'd0);
    chk("async rst out_res",   32'(b8.out_res),   32'd0);
    chk("async rst out_flags", 32'(b8.out_flags), 32'd0);
    q.delete();
    head_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post rst in_ready", 32'(b8.in_ready), 32'd1);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (b8.out_valid) n++;
    end
    chk("post rst no out_valid", 32'(n), 32'd0);
    @(posedge clk); #1;

    // 16-bit random ops with consumer stalls and request gaps
    sel16 = 1'b1;
    rnd_stall = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = 16'($urandom);
      r_b  = 16'($urandom);
      model(16, r_op, r_a, r_b, e_res, e_fl, e_lat);
      send(r_op, r_a, r_b, e_res, e_fl, e_lat, $sformatf("rnd%0d op%0d", i, r_op));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    rnd_stall = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
